// File: rtl/bn_pkg.sv
// rtl/bn_pkg.sv - shared BN fixed-point helpers and FSM state type
package bn_pkg;

  localparam int FRAC_BITS_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  // Clamp a wide signed value into the signed range of a dw-bit word
  function automatic logic signed [63:0] sat_to_dw(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) begin
      sat_to_dw = hi;
    end else if (v < lo) begin
      sat_to_dw = lo;
    end else begin
      sat_to_dw = v;
    end
  endfunction

endpackage

// File: rtl/adj_bp_if.sv
// rtl/adj_bp_if.sv - sample/gradient bundle between the BN backward stages
interface adj_bp_if #(
  parameter int DATA_WIDTH = 16
);
  logic                         start_bn_bp_in;
  logic                         clear_in;
  logic signed [DATA_WIDTH-1:0] dy_in;
  logic signed [DATA_WIDTH-1:0] xhat_in;
  logic signed [DATA_WIDTH-1:0] gamma_in;
  logic                         start_bn_bp_out;
  logic signed [DATA_WIDTH-1:0] dxhat_out;
  logic signed [DATA_WIDTH-1:0] dgamma_out;
  logic signed [DATA_WIDTH-1:0] dbeta_out;
  logic                         grad_valid_out;
  logic                         busy_out;

  modport slave (
    input  start_bn_bp_in, clear_in, dy_in, xhat_in, gamma_in,
    output start_bn_bp_out, dxhat_out, dgamma_out, dbeta_out, grad_valid_out, busy_out
  );

  modport master (
    output start_bn_bp_in, clear_in, dy_in, xhat_in, gamma_in,
    input  start_bn_bp_out, dxhat_out, dgamma_out, dbeta_out, grad_valid_out, busy_out
  );
endinterface

// File: rtl/bn_sat_mul.sv
// rtl/bn_sat_mul.sv - signed fixed-point multiply, truncating shift, saturate
module bn_sat_mul
  import bn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = FRAC_BITS_DEF
) (
  input  logic signed [DATA_WIDTH-1:0] i_a,
  input  logic signed [DATA_WIDTH-1:0] i_b,
  output logic signed [DATA_WIDTH-1:0] o_p
);

  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [63:0]             w_shift;

  assign w_prod  = i_a * i_b;
  // Sign-extend before the arithmetic shift so truncation rounds toward -inf
  assign w_shift = 64'(w_prod) >>> FRAC_BITS;
  assign o_p     = DATA_WIDTH'(sat_to_dw(w_shift, DATA_WIDTH));

endmodule

// File: rtl/adj_bp.sv
// rtl/adj_bp.sv - BN adjust backward pass: dxhat stream plus per-batch dgamma/dbeta
module adj_bp
  import bn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = FRAC_BITS_DEF,
  parameter int MINI_BATCH = 64
) (
  input logic     clk,
  input logic     rst_n,
  adj_bp_if.slave bus
);

  localparam int ADDR_WIDTH = $clog2(MINI_BATCH);
  localparam int ACC_WIDTH  = DATA_WIDTH + ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_CNT = ADDR_WIDTH'(MINI_BATCH - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_WIDTH-1:0]        r_cnt;
  logic signed [ACC_WIDTH-1:0]  r_acc_beta;
  logic signed [ACC_WIDTH-1:0]  r_acc_gamma;
  logic                         r_start_out;
  logic signed [DATA_WIDTH-1:0] r_dxhat;
  logic signed [DATA_WIDTH-1:0] r_dgamma;
  logic signed [DATA_WIDTH-1:0] r_dbeta;
  logic                         r_grad_valid;

  logic signed [DATA_WIDTH-1:0] w_dxhat_mul;
  logic signed [DATA_WIDTH-1:0] w_dg_mul;
  logic signed [ACC_WIDTH-1:0]  w_dy_ext;
  logic signed [ACC_WIDTH-1:0]  w_dg_ext;
  logic signed [ACC_WIDTH-1:0]  w_beta_sum;
  logic signed [ACC_WIDTH-1:0]  w_gamma_sum;
  logic                         w_valid;
  logic                         w_last;
  logic                         w_load;
  logic                         w_add;
  logic                         w_fin;

  bn_sat_mul #(.DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS)) u_mul_dxhat (
    .i_a (bus.gamma_in),
    .i_b (bus.dy_in),
    .o_p (w_dxhat_mul)
  );

  bn_sat_mul #(.DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS)) u_mul_dgamma (
    .i_a (bus.dy_in),
    .i_b (bus.xhat_in),
    .o_p (w_dg_mul)
  );

  assign w_valid     = bus.start_bn_bp_in;
  assign w_last      = (r_cnt == LAST_CNT);
  assign w_dy_ext    = ACC_WIDTH'(bus.dy_in);
  assign w_dg_ext    = ACC_WIDTH'(w_dg_mul);
  assign w_beta_sum  = r_acc_beta + w_dy_ext;
  assign w_gamma_sum = r_acc_gamma + w_dg_ext;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: clear always wins, final sample returns to IDLE
  always_comb begin
    w_state_nxt = r_state;
    if (bus.clear_in) begin
      w_state_nxt = IDLE;
    end else if (w_valid) begin
      case (r_state)
        IDLE:    w_state_nxt = ACC;
        ACC:     w_state_nxt = w_last ? IDLE : ACC;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // FSM outputs: which accumulator action this cycle performs
  always_comb begin
    w_load = 1'b0;
    w_add  = 1'b0;
    w_fin  = 1'b0;
    if (!bus.clear_in && w_valid) begin
      if (r_state == IDLE) begin
        w_load = 1'b1;
      end else if (w_last) begin
        w_fin = 1'b1;
      end else begin
        w_add = 1'b1;
      end
    end
  end

  // Sample counter and batch accumulators
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_acc_beta  <= '0;
      r_acc_gamma <= '0;
    end else if (bus.clear_in || w_fin) begin
      r_cnt       <= '0;
      r_acc_beta  <= '0;
      r_acc_gamma <= '0;
    end else if (w_load) begin
      r_cnt       <= ADDR_WIDTH'(1);
      r_acc_beta  <= w_dy_ext;
      r_acc_gamma <= w_dg_ext;
    end else if (w_add) begin
      r_cnt       <= r_cnt + ADDR_WIDTH'(1);
      r_acc_beta  <= w_beta_sum;
      r_acc_gamma <= w_gamma_sum;
    end
  end

  // Gradient outputs load only on the batch's final sample and hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dgamma     <= '0;
      r_dbeta      <= '0;
      r_grad_valid <= 1'b0;
    end else begin
      r_grad_valid <= w_fin;
      if (w_fin) begin
        r_dgamma <= DATA_WIDTH'(sat_to_dw(64'(w_gamma_sum), DATA_WIDTH));
        r_dbeta  <= DATA_WIDTH'(sat_to_dw(64'(w_beta_sum), DATA_WIDTH));
      end
    end
  end

  // dxhat stream: fixed one-cycle latency regardless of FSM or clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_out <= 1'b0;
      r_dxhat     <= '0;
    end else begin
      r_start_out <= w_valid;
      r_dxhat     <= w_valid ? w_dxhat_mul : '0;
    end
  end

  assign bus.start_bn_bp_out = r_start_out;
  assign bus.dxhat_out       = r_dxhat;
  assign bus.dgamma_out      = r_dgamma;
  assign bus.dbeta_out       = r_dbeta;
  assign bus.grad_valid_out  = r_grad_valid;
  assign bus.busy_out        = (r_state == ACC);

endmodule

// File: tb/tb_adj_bp.sv
// tb/tb_adj_bp.sv - directed self-checking bench for adj_bp
module tb_adj_bp;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  adj_bp_if #(.DATA_WIDTH(16)) u_if ();

  adj_bp #(.DATA_WIDTH(16), .FRAC_BITS(8), .MINI_BATCH(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic v, input logic [15:0] dy, input logic [15:0] xh);
    u_if.start_bn_bp_in = v;
    u_if.dy_in          = dy;
    u_if.xhat_in        = xh;
    tick();
  endtask

  logic [15:0] xh_tab [4];

  initial begin
    n_chk = 0;
    n_pass = 0;
    xh_tab[0] = 16'h0080;
    xh_tab[1] = 16'h0100;
    xh_tab[2] = 16'hFF80;
    xh_tab[3] = 16'h0200;
    rst_n = 1'b0;
    u_if.start_bn_bp_in = 1'b0;
    u_if.clear_in = 1'b0;
    u_if.dy_in = '0;
    u_if.xhat_in = '0;
    u_if.gamma_in = 16'h0200;
    repeat (2) tick();
    chk("rst_start", 16'(u_if.start_bn_bp_out), 16'h0);
    chk("rst_dxhat", u_if.dxhat_out, 16'h0);
    chk("rst_dgamma", u_if.dgamma_out, 16'h0);
    chk("rst_dbeta", u_if.dbeta_out, 16'h0);
    chk("rst_gv", 16'(u_if.grad_valid_out), 16'h0);
    chk("rst_busy", 16'(u_if.busy_out), 16'h0);
    rst_n = 1'b1;
    tick();

    // 1: single-sample dxhat latency
    send(1'b1, 16'h0100, 16'h0000);
    chk("t1_start", 16'(u_if.start_bn_bp_out), 16'h1);
    chk("t1_dxhat", u_if.dxhat_out, 16'h0200);
    chk("t1_busy", 16'(u_if.busy_out), 16'h1);
    send(1'b0, 16'h0100, 16'h0000);
    chk("t1_start_lo", 16'(u_if.start_bn_bp_out), 16'h0);
    chk("t1_dxhat_lo", u_if.dxhat_out, 16'h0);
    u_if.clear_in = 1'b1;
    send(1'b0, 16'h0, 16'h0);
    u_if.clear_in = 1'b0;
    chk("t1_clr_busy", 16'(u_if.busy_out), 16'h0);
    chk("t1_clr_gv", 16'(u_if.grad_valid_out), 16'h0);

    // 2: contiguous batch
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 16'h0100, xh_tab[i]);
      chk("t2_gv", 16'(u_if.grad_valid_out), (i == 3) ? 16'h1 : 16'h0);
    end
    chk("t2_dbeta", u_if.dbeta_out, 16'h0400);
    chk("t2_dgamma", u_if.dgamma_out, 16'h0300);
    chk("t2_busy", 16'(u_if.busy_out), 16'h0);
    send(1'b0, 16'h0, 16'h0);
    chk("t2_gv_drop", 16'(u_if.grad_valid_out), 16'h0);

    // 3: same batch with idle gaps
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 16'h0100, xh_tab[i]);
      chk("t3_gv", 16'(u_if.grad_valid_out), (i == 3) ? 16'h1 : 16'h0);
      if (i < 3) begin
        for (int g = 0; g < 3; g++) begin
          send(1'b0, 16'h0, 16'h0);
          chk("t3_gap_gv", 16'(u_if.grad_valid_out), 16'h0);
          chk("t3_gap_busy", 16'(u_if.busy_out), 16'h1);
        end
      end
    end
    chk("t3_dbeta", u_if.dbeta_out, 16'h0400);
    chk("t3_dgamma", u_if.dgamma_out, 16'h0300);

    // 4: positive and negative saturation
    u_if.gamma_in = 16'h7FFF;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 16'h7FFF, 16'h7FFF);
      chk("t4_dxhat", u_if.dxhat_out, 16'h7FFF);
    end
    chk("t4_gv", 16'(u_if.grad_valid_out), 16'h1);
    chk("t4_dbeta", u_if.dbeta_out, 16'h7FFF);
    chk("t4_dgamma", u_if.dgamma_out, 16'h7FFF);
    u_if.gamma_in = 16'h8000;
    send(1'b1, 16'h7FFF, 16'h0000);
    chk("t4_dxhat_neg", u_if.dxhat_out, 16'h8000);

    // 5: partial batch, clear (with a same-cycle sample), then a fresh batch
    u_if.gamma_in = 16'h0200;
    send(1'b1, 16'h0100, 16'h0100);
    send(1'b1, 16'h0100, 16'h0100);
    chk("t5_busy", 16'(u_if.busy_out), 16'h1);
    chk("t5_hold_dbeta", u_if.dbeta_out, 16'h7FFF);
    u_if.clear_in = 1'b1;
    send(1'b1, 16'h0100, 16'h0100);
    u_if.clear_in = 1'b0;
    chk("t5_clr_dxhat", u_if.dxhat_out, 16'h0200);
    chk("t5_clr_busy", 16'(u_if.busy_out), 16'h0);
    chk("t5_clr_gv", 16'(u_if.grad_valid_out), 16'h0);
    chk("t5_clr_dgamma", u_if.dgamma_out, 16'h7FFF);
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 16'h0010, 16'h0100);
      if (i < 3) begin
        chk("t5_hold_dbeta2", u_if.dbeta_out, 16'h7FFF);
        chk("t5_gv_lo", 16'(u_if.grad_valid_out), 16'h0);
      end
    end
    chk("t5_gv", 16'(u_if.grad_valid_out), 16'h1);
    chk("t5_dbeta", u_if.dbeta_out, 16'h0040);
    chk("t5_dgamma", u_if.dgamma_out, 16'h0040);

    // 6: async reset mid-batch, then back-to-back batches
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 16'h0100, 16'h0100);
    end
    u_if.start_bn_bp_in = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_dbeta", u_if.dbeta_out, 16'h0);
    chk("t6_rst_dgamma", u_if.dgamma_out, 16'h0);
    chk("t6_rst_busy", 16'(u_if.busy_out), 16'h0);
    chk("t6_rst_start", 16'(u_if.start_bn_bp_out), 16'h0);
    chk("t6_rst_dxhat", u_if.dxhat_out, 16'h0);
    chk("t6_rst_gv", 16'(u_if.grad_valid_out), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(1'b1, (i < 4) ? 16'h0020 : 16'hFFFF, 16'h0100);
      chk("t6_gv", 16'(u_if.grad_valid_out), (i == 3 || i == 7) ? 16'h1 : 16'h0);
      chk("t6_busy", 16'(u_if.busy_out), (i == 3 || i == 7) ? 16'h0 : 16'h1);
      if (i == 3) begin
        chk("t6_dbeta1", u_if.dbeta_out, 16'h0080);
        chk("t6_dgamma1", u_if.dgamma_out, 16'h0080);
      end
      if (i == 7) begin
        chk("t6_dbeta2", u_if.dbeta_out, 16'hFFFC);
        chk("t6_dgamma2", u_if.dgamma_out, 16'hFFFC);
      end
    end
    send(1'b0, 16'h0, 16'h0);
    chk("t6_gv_end", 16'(u_if.grad_valid_out), 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
